// File: rtl/rotator_pkg.sv
// Shared types and width helpers for the multi-cycle left rotator.
package rotator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    function automatic int amount_width(input int width);
        return (clog2(width) < 1) ? 1 : clog2(width);
    endfunction

    function automatic int stage_count(input int width);
        return amount_width(width);
    endfunction

endpackage

// File: rtl/rotator_left.sv
// Fixed-distance combinational left rotation; ROTATION is reduced modulo WIDTH.
module rotator_left #(
    parameter int WIDTH    = 8,
    parameter int ROTATION = 1
) (
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] rotated
);

    localparam int R = ROTATION % WIDTH;

    generate
        if (R == 0) begin : g_pass
            assign rotated = data;
        end else begin : g_rot
            assign rotated = {data[WIDTH-1-R:0], data[WIDTH-1:WIDTH-R]};
        end
    endgenerate

endmodule

// File: rtl/rotator_left_sequencer.sv
// Multi-cycle left rotator applying one power-of-two stage per clock.
// Define ROTATOR_LEFT_SEQUENCER_SKIP_EN to visit only the set amount bits.
module rotator_left_sequencer
    import rotator_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int AMOUNT_WIDTH = amount_width(WIDTH)
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [AMOUNT_WIDTH-1:0] in_amount,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    busy
);

    localparam int STAGES    = stage_count(WIDTH);
    localparam int CNT_WIDTH = (clog2(STAGES) < 1) ? 1 : clog2(STAGES);

    state_t                  state, state_d;
    logic [WIDTH-1:0]        data_q, data_d;
    logic [AMOUNT_WIDTH-1:0] amount_q, amount_d, amount_in;
    logic [CNT_WIDTH-1:0]    sel;
    logic                    ready_en;
    logic [WIDTH-1:0]        stage_out [STAGES];

    generate
        if ((WIDTH & (WIDTH - 1)) == 0) begin : g_pow2
            assign amount_in = in_amount;
        end else begin : g_mod
            assign amount_in = AMOUNT_WIDTH'(32'(in_amount) % 32'(WIDTH));
        end

        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            rotator_left #(
                .WIDTH   (WIDTH),
                .ROTATION(2 ** k)
            ) u_rot (
                .data   (data_q),
                .rotated(stage_out[k])
            );
        end
    endgenerate

`ifdef ROTATOR_LEFT_SEQUENCER_SKIP_EN
    // Stage index is the lowest bit still set in the remaining amount.
    always_comb begin
        sel = '0;
        for (int unsigned i = STAGES; i > 0; i--) begin
            if (amount_q[i-1]) sel = CNT_WIDTH'(i - 1);
        end
    end
`else
    logic [CNT_WIDTH-1:0] stage_cnt, stage_cnt_d;
    assign sel = stage_cnt;
`endif

    always_comb begin
        state_d  = state;
        data_d   = data_q;
        amount_d = amount_q;
`ifndef ROTATOR_LEFT_SEQUENCER_SKIP_EN
        stage_cnt_d = stage_cnt;
`endif
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    data_d   = in_data;
                    amount_d = amount_in;
`ifdef ROTATOR_LEFT_SEQUENCER_SKIP_EN
                    state_d  = (amount_in == '0) ? DONE : BUSY;
`else
                    stage_cnt_d = '0;
                    state_d     = BUSY;
`endif
                end
            end
            BUSY: begin
                if (amount_q[sel]) data_d = stage_out[sel];
`ifdef ROTATOR_LEFT_SEQUENCER_SKIP_EN
                amount_d = amount_q & (amount_q - AMOUNT_WIDTH'(1));
                if (amount_d == '0) state_d = DONE;
`else
                stage_cnt_d = stage_cnt + CNT_WIDTH'(1);
                if (stage_cnt == CNT_WIDTH'(STAGES - 1)) state_d = DONE;
`endif
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            data_q    <= '0;
            amount_q  <= '0;
            ready_en  <= 1'b0;
`ifndef ROTATOR_LEFT_SEQUENCER_SKIP_EN
            stage_cnt <= '0;
`endif
        end else begin
            state     <= state_d;
            data_q    <= data_d;
            amount_q  <= amount_d;
            ready_en  <= 1'b1;
`ifndef ROTATOR_LEFT_SEQUENCER_SKIP_EN
            stage_cnt <= stage_cnt_d;
`endif
        end
    end

    // ready_en keeps in_ready low until the first edge after reset release.
    assign in_ready  = ready_en && (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY) || (state == DONE);
    assign out_data  = data_q;

endmodule

// File: tb/tb_rotator_left_sequencer.sv
// Self-checking bench for rotator_left_sequencer at WIDTH=8 and WIDTH=5.
module tb_rotator_left_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       resetn;
    logic       iv8, ir8, ov8, or8, busy8;
    logic [7:0] id8, od8;
    logic [2:0] ia8;
    logic       iv5, ir5, ov5, or5, busy5;
    logic [4:0] id5, od5;
    logic [2:0] ia5;

    int checks = 0;
    int errors = 0;

    rotator_left_sequencer #(.WIDTH(8)) dut8 (
        .clock(clock), .resetn(resetn),
        .in_valid(iv8), .in_ready(ir8), .in_data(id8), .in_amount(ia8),
        .out_valid(ov8), .out_ready(or8), .out_data(od8), .busy(busy8)
    );

    rotator_left_sequencer #(.WIDTH(5)) dut5 (
        .clock(clock), .resetn(resetn),
        .in_valid(iv5), .in_ready(ir5), .in_data(id5), .in_amount(ia5),
        .out_valid(ov5), .out_ready(or5), .out_data(od5), .busy(busy5)
    );

    function automatic int rotl_ref(input int w, input int d, input int a);
        int r, mask;
        r    = a % w;
        mask = (1 << w) - 1;
        d    = d & mask;
        return ((d << r) | (d >> (w - r))) & mask;
    endfunction

    function automatic int exp_lat(input int w, input int a);
`ifdef ROTATOR_LEFT_SEQUENCER_SKIP_EN
        return $countones(a % w) + 1;
`else
        int s;
        s = 0;
        while ((1 << s) < w) s++;
        if (s < 1) s = 1;
        return s + 1;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    function automatic logic rdy(input int w);
        return (w == 8) ? ir8 : ir5;
    endfunction

    function automatic logic vld(input int w);
        return (w == 8) ? ov8 : ov5;
    endfunction

    function automatic int odat(input int w);
        return (w == 8) ? int'(od8) : int'(od5);
    endfunction

    // Presents one request, waits for acceptance, then counts cycles to out_valid.
    task automatic request(input int w, input int d, input int a, output int got, output int lat);
        int guard;
        guard = 0;
        if (w == 8) begin iv8 = 1'b1; id8 = d[7:0]; ia8 = a[2:0]; end
        else        begin iv5 = 1'b1; id5 = d[4:0]; ia5 = a[2:0]; end
        while (!rdy(w) && guard < 50) begin step(); guard++; end
        if (guard >= 50) check("accept_timeout", guard, 0);
        step();
        if (w == 8) iv8 = 1'b0; else iv5 = 1'b0;
        lat = 1;
        while (!vld(w) && lat < 40) begin step(); lat++; end
        got = odat(w);
    endtask

    task automatic release_out(input int w);
        if (w == 8) or8 = 1'b1; else or5 = 1'b1;
        step();
        if (w == 8) or8 = 1'b0; else or5 = 1'b0;
    endtask

    typedef struct { int w; int d; int a; } vec_t;

    initial begin
        vec_t vecs [$];
        int   got, lat, held;
        int   q [$];
        int   accepted, guard;
        logic [7:0] rd;
        logic [2:0] ra;

        resetn = 1'b0;
        iv8 = 0; id8 = '0; ia8 = '0; or8 = 0;
        iv5 = 0; id5 = '0; ia5 = '0; or5 = 0;

        #12;
        check("rst_in_ready",  ir8,   0);
        check("rst_out_valid", ov8,   0);
        check("rst_out_data",  od8,   0);
        check("rst_busy",      busy8, 0);
        check("rst_in_ready5", ir5,   0);
        @(negedge clock);
        resetn = 1'b1;
        step();
        check("post_rst_in_ready", ir8, 1);

        vecs = '{'{8, 'h81, 1}, '{8, 'h01, 5}, '{8, 'hA5, 7}, '{8, 'h3C, 0},
                 '{5, 'h01, 7}, '{5, 'h13, 0}, '{5, 'h16, 5}, '{5, 'h0B, 6},
                 '{5, 'h1E, 3}};
        foreach (vecs[i]) begin
            request(vecs[i].w, vecs[i].d, vecs[i].a, got, lat);
            check($sformatf("dir_data_w%0d_a%0d", vecs[i].w, vecs[i].a), got,
                  rotl_ref(vecs[i].w, vecs[i].d, vecs[i].a));
            check($sformatf("dir_lat_w%0d_a%0d", vecs[i].w, vecs[i].a), lat,
                  exp_lat(vecs[i].w, vecs[i].a));
            release_out(vecs[i].w);
            check("dir_idle_ready", rdy(vecs[i].w), 1);
            check("dir_idle_valid", vld(vecs[i].w), 0);
        end

        for (int i = 0; i < 30; i++) begin
            int d, a;
            d = $urandom_range(0, 31);
            a = $urandom_range(0, 7);
            request(5, d, a, got, lat);
            check("rnd5_data", got, rotl_ref(5, d, a));
            check("rnd5_lat", lat, exp_lat(5, a));
            release_out(5);
        end

        // Backpressure: result must hold and new requests must be ignored.
        request(8, 'h3C, 3, got, lat);
        check("bp_data", got, 'hE1);
        held = got;
        for (int i = 0; i < 10; i++) begin
            iv8 = 1'b1; id8 = 8'($urandom); ia8 = 3'($urandom);
            step();
            check("bp_hold_data", od8, held);
            check("bp_in_ready",  ir8, 0);
            check("bp_busy",      busy8, 1);
            check("bp_valid",     ov8, 1);
        end
        iv8 = 1'b0;
        release_out(8);
        check("bp_rel_ready", ir8, 1);
        check("bp_rel_valid", ov8, 0);
        check("bp_rel_busy",  busy8, 0);
        step();
        check("bp_no_accept", busy8, 0);

        // Reset while BUSY discards the word immediately.
        iv8 = 1'b1; id8 = 8'hAA; ia8 = 3'd3;
        step();
        iv8 = 1'b0;
        step();
        check("mid_busy", busy8, 1);
        resetn = 1'b0;
        #1;
        check("mid_rst_valid", ov8,   0);
        check("mid_rst_ready", ir8,   0);
        check("mid_rst_busy",  busy8, 0);
        check("mid_rst_data",  od8,   0);
        @(negedge clock);
        resetn = 1'b1;
        step();
        check("mid_rel_ready", ir8, 1);
        request(8, 'h0F, 4, got, lat);
        check("mid_after_data", got, 'hF0);
        check("mid_after_lat",  lat, exp_lat(8, 4));
        release_out(8);

        // Random traffic against a queue scoreboard.
        accepted = 0;
        guard    = 0;
        while ((accepted < 1000 || q.size() > 0) && guard < 40000) begin
            rd  = 8'($urandom);
            ra  = 3'($urandom);
            iv8 = (accepted < 1000) && ($urandom_range(0, 3) != 0);
            id8 = rd;
            ia8 = ra;
            or8 = ($urandom_range(0, 2) != 0);
            if (iv8 && ir8) begin
                q.push_back(rotl_ref(8, int'(rd), int'(ra)));
                accepted++;
            end
            if (ov8 && or8) begin
                check("rand_out_expected", q.size() > 0, 1);
                if (q.size() > 0) check("rand_data", od8, q.pop_front());
            end
            step();
            guard++;
        end
        iv8 = 1'b0;
        or8 = 1'b0;
        check("rand_accepted", accepted, 1000);
        check("rand_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
